joy_serializer: RTL and testbench

- Responder end of the joystick shift-register link read by joydecoder: emulates the 74HC165-style chain on the joystick adapter.
- Takes the MEGA65 native DB9 joystick lines (raw, active-low), synchronises and debounces them, and loads them into a 16-bit frame.
- Shifts the frame out on joy_data under the host's joy_load_n / joy_clk.
- Lets the existing joydecoder and zxuno core consume native joysticks unchanged. Also drives the joydecoder bench.

---
 rtl/joy_pkg.sv | 37 +++
 rtl/joy_debounce.sv | 76 +++++++
 rtl/joy_serializer.sv | 131 +++++++++++++
 tb/tb_joy_serializer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/joy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : joy_pkg
// Description : Shared constants, state encoding and frame builder for the
//               native-joystick serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package joy_pkg;

    // Bit positions inside an 8-bit raw/debounced port vector
    localparam int JOY_UP    = 0;
    localparam int JOY_DOWN  = 1;
    localparam int JOY_LEFT  = 2;
    localparam int JOY_RIGHT = 3;
    localparam int JOY_FIRE1 = 4;
    localparam int JOY_FIRE2 = 5;
    localparam int JOY_FIRE3 = 6;
    localparam int JOY_START = 7;

    // Serial frame length seen by the host decoder
    localparam int FRAME_BITS = 16;

    typedef enum logic [0:0] {
        LOAD  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Frame order puts "up" first on the wire for each port, port 1 before port 2
    function automatic logic [15:0] build_frame(input logic [7:0] j1, input logic [7:0] j2);
        build_frame = {j1[JOY_UP], j1[JOY_DOWN], j1[JOY_LEFT], j1[JOY_RIGHT],
                       j1[JOY_FIRE1], j1[JOY_FIRE2], j1[JOY_FIRE3], j1[JOY_START],
                       j2[JOY_UP], j2[JOY_DOWN], j2[JOY_LEFT], j2[JOY_RIGHT],
                       j2[JOY_FIRE1], j2[JOY_FIRE2], j2[JOY_FIRE3], j2[JOY_START]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/joy_debounce.sv
`default_nettype none
// ============================================================================
// Module      : joy_debounce
// Description : 2-FF synchroniser plus stability-counter debouncer for one
//               active-low joystick port vector.
// Revision    : 1.0 - initial release
// ============================================================================
module joy_debounce #(
    parameter int WIDTH  = 8,
    parameter int CYCLES = 28000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_raw_n,
    output logic [WIDTH-1:0] o_db_n
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    // Two-flop synchroniser; idles high so released buttons read as not pressed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= i_raw_n;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (CYCLES == 0) begin : g_bypass
            assign o_db_n = r_sync2;
        end else begin : g_filter
            localparam int            CW        = $clog2(CYCLES + 1);
            localparam logic [CW-1:0] c_cnt_max = CW'(CYCLES);

            logic [WIDTH-1:0] r_prev;
            logic [WIDTH-1:0] r_db;
            logic [CW-1:0]    r_cnt;
            logic [CW-1:0]    w_cnt_next;
            logic             w_changed;

            // Any difference from last cycle restarts the stability window
            always_comb begin
                w_changed  = (r_sync2 != r_prev);
                w_cnt_next = r_cnt;
                if (w_changed) begin
                    w_cnt_next = '0;
                end else if (r_cnt != c_cnt_max) begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end

            // Counter, history and debounced output register
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_prev <= '1;
                    r_db   <= '1;
                    r_cnt  <= '0;
                end else begin
                    r_prev <= r_sync2;
                    r_cnt  <= w_cnt_next;
                    if (!w_changed && (w_cnt_next == c_cnt_max)) begin
                        r_db <= r_sync2;
                    end
                end
            end

            assign o_db_n = r_db;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/joy_serializer.sv
`default_nettype none
// ============================================================================
// Module      : joy_serializer
// Description : Emulates a 74HC165-style chain: debounced native DB9 joystick
//               lines are loaded into a 16-bit frame and shifted out under
//               the host's asynchronous joy_load_n / joy_clk.
// Revision    : 1.0 - initial release
// ============================================================================
module joy_serializer
    import joy_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 28000,
    parameter int FRAME_BITS      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] joy1_n,
    input  logic [7:0] joy2_n,
    input  logic       joy_clk,
    input  logic       joy_load_n,
    output logic       joy_data,
    output logic [7:0] joy1_db_n,
    output logic [7:0] joy2_db_n,
    output logic       frame_done
);

    localparam int            CW         = $clog2(FRAME_BITS + 1);
    localparam logic [CW-1:0] c_cnt_last = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0] c_cnt_full = CW'(FRAME_BITS);

    logic [2:0]            r_jclk_s;
    logic [1:0]            r_load_s;
    logic [FRAME_BITS-1:0] r_shift;
    logic [CW-1:0]         r_cnt;
    logic                  r_done;
    state_t                r_state;
    state_t                w_state_next;
    logic                  w_load_en;
    logic                  w_shift_en;
    logic                  w_clk_rise;
    logic                  w_load_n_s;
    logic [15:0]           w_frame;

    joy_debounce #(.WIDTH(8), .CYCLES(DEBOUNCE_CYCLES)) u_db1 (
        .clk     (clk),
        .rst     (rst),
        .i_raw_n (joy1_n),
        .o_db_n  (joy1_db_n)
    );

    joy_debounce #(.WIDTH(8), .CYCLES(DEBOUNCE_CYCLES)) u_db2 (
        .clk     (clk),
        .rst     (rst),
        .i_raw_n (joy2_n),
        .o_db_n  (joy2_db_n)
    );

    // Synchronise host control lines; joy_clk keeps a third stage for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_jclk_s <= '1;
            r_load_s <= '1;
        end else begin
            r_jclk_s <= {r_jclk_s[1:0], joy_clk};
            r_load_s <= {r_load_s[0], joy_load_n};
        end
    end

    assign w_clk_rise = r_jclk_s[1] & ~r_jclk_s[2];
    assign w_load_n_s = r_load_s[1];
    assign w_frame    = build_frame(joy1_db_n, joy2_db_n);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and datapath enables; a low load always wins over a clock edge
    always_comb begin
        w_state_next = r_state;
        w_load_en    = 1'b0;
        w_shift_en   = 1'b0;
        case (r_state)
            LOAD: begin
                w_load_en = 1'b1;
                if (w_load_n_s) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (!w_load_n_s) begin
                    w_state_next = LOAD;
                    w_load_en    = 1'b1;
                end else if (w_clk_rise && (r_cnt != c_cnt_full)) begin
                    w_shift_en = 1'b1;
                end
            end
            default: begin
                w_state_next = LOAD;
            end
        endcase
    end

    // Shift register, bit counter and end-of-frame pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '1;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load_en) begin
                r_shift <= FRAME_BITS'(w_frame);
                r_cnt   <= '0;
            end else if (w_shift_en) begin
                r_shift <= {r_shift[FRAME_BITS-2:0], 1'b1};
                r_cnt   <= r_cnt + CW'(1);
                r_done  <= (r_cnt == c_cnt_last);
            end
        end
    end

    assign joy_data   = r_shift[FRAME_BITS-1];
    assign frame_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_joy_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_joy_serializer
// Description : Self-checking bench for joy_serializer with a frame scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_joy_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] joy1_n;
    logic [7:0] joy2_n;
    logic       joy_clk;
    logic       joy_load_n;
    logic       joy_data;
    logic [7:0] joy1_db_n;
    logic [7:0] joy2_db_n;
    logic       frame_done;

    int n_checks;
    int n_fail;
    int done_cnt;
    logic [15:0] sb_q[$];

    joy_serializer #(.DEBOUNCE_CYCLES(4), .FRAME_BITS(16)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .joy1_n     (joy1_n),
        .joy2_n     (joy2_n),
        .joy_clk    (joy_clk),
        .joy_load_n (joy_load_n),
        .joy_data   (joy_data),
        .joy1_db_n  (joy1_db_n),
        .joy2_db_n  (joy2_db_n),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count end-of-frame pulses, sampled on the inactive edge
    initial done_cnt = 0;
    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference frame: up first, start last, port 1 ahead of port 2
    function automatic logic [15:0] ref_frame(input logic [7:0] j1, input logic [7:0] j2);
        logic [15:0] f;
        for (int i = 0; i < 8; i++) begin
            f[15 - i] = j1[i];
            f[7 - i]  = j2[i];
        end
        return f;
    endfunction

    // Host load pulse; the frame the DUT should now hold goes on the scoreboard
    task automatic load_pulse();
        joy_load_n = 1'b0;
        wait_neg(4);
        joy_load_n = 1'b1;
        sb_q.push_back(ref_frame(joy1_n, joy2_n));
        wait_neg(4);
    endtask

    // Sample joy_data before each rising joy_clk, as the 165 host does
    task automatic shift_bits(input int n, output logic [15:0] cap);
        cap = '0;
        for (int i = 0; i < n; i++) begin
            cap = {cap[14:0], joy_data};
            joy_clk = 1'b1;
            wait_neg(4);
            joy_clk = 1'b0;
            wait_neg(4);
        end
    endtask

    task automatic settle_ports(input logic [7:0] j1, input logic [7:0] j2);
        joy1_n = j1;
        joy2_n = j2;
        wait_neg(10);
    endtask

    task automatic full_frame(input string tag);
        logic [15:0] cap;
        logic [15:0] exp;
        int d0;
        d0 = done_cnt;
        shift_bits(16, cap);
        exp = sb_q.pop_front();
        chk({tag, "_frame"}, {16'h0, cap}, {16'h0, exp});
        chk({tag, "_done"}, done_cnt - d0, 1);
        chk({tag, "_tail"}, {31'h0, joy_data}, 32'h1);
    endtask

    initial begin
        logic [15:0] cap;
        logic [15:0] exp;
        logic        bad;
        int          d0;
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        joy1_n     = 8'hFF;
        joy2_n     = 8'hFF;
        joy_clk    = 1'b0;
        joy_load_n = 1'b1;

        // Reset state
        wait_neg(3);
        chk("rst_data", {31'h0, joy_data}, 32'h1);
        chk("rst_db1", {24'h0, joy1_db_n}, 32'hFF);
        chk("rst_db2", {24'h0, joy2_db_n}, 32'hFF);
        chk("rst_done", {31'h0, frame_done}, 32'h0);
        rst = 1'b0;
        wait_neg(4);

        // Up on port 1
        settle_ports(8'hFE, 8'hFF);
        chk("db1_up", {24'h0, joy1_db_n}, 32'hFE);
        chk("db2_idle", {24'h0, joy2_db_n}, 32'hFF);
        load_pulse();
        full_frame("up1");

        // Bounce shorter than the debounce window never propagates
        settle_ports(8'hFF, 8'hFF);
        chk("db1_release", {24'h0, joy1_db_n}, 32'hFF);
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (i % 3 == 0) joy1_n = ~joy1_n;
            @(negedge clk);
            if (joy1_db_n !== 8'hFF) bad = 1'b1;
        end
        chk("bounce_filtered", {31'h0, bad}, 32'h0);
        settle_ports(8'hFF, 8'hFF);

        // Start on port 2, then overclock the tail
        settle_ports(8'hFF, 8'h7F);
        chk("db2_start", {24'h0, joy2_db_n}, 32'h7F);
        load_pulse();
        full_frame("start2");
        d0 = done_cnt;
        shift_bits(4, cap);
        chk("extra_edges_ones", {28'h0, cap[3:0]}, 32'hF);
        chk("extra_edges_nodone", done_cnt - d0, 0);

        // Load during a frame aborts it and restarts from bit 15
        settle_ports(8'hA5, 8'h3C);
        d0 = done_cnt;
        load_pulse();
        shift_bits(5, cap);
        exp = sb_q.pop_front();
        chk("abort_partial", {27'h0, cap[4:0]}, {27'h0, exp[15:11]});
        load_pulse();
        chk("abort_nodone", done_cnt - d0, 0);
        full_frame("after_abort");

        // Reset in mid-frame
        settle_ports(8'h5A, 8'hC3);
        load_pulse();
        shift_bits(8, cap);
        exp = sb_q.pop_front();
        chk("prerst_partial", {24'h0, cap[7:0]}, {24'h0, exp[15:8]});
        rst = 1'b1;
        #1;
        chk("midrst_data", {31'h0, joy_data}, 32'h1);
        wait_neg(3);
        chk("midrst_db1", {24'h0, joy1_db_n}, 32'hFF);
        rst = 1'b0;
        wait_neg(10);
        load_pulse();
        full_frame("post_rst");

        chk("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
